// File: rtl/rst_req_initiator_pkg.sv
// rtl/rst_req_initiator_pkg.sv - shared types and helpers for the reset request initiator
// Purpose: FSM state encoding, counter widths and a width helper shared by the block.
// Ports: none (package).
package rst_req_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_REL  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int REQ_COUNT_W = 8;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_req_initiator_if.sv
// rtl/rst_req_initiator_if.sv - request sources and req/ack handshake bundle
// Purpose: groups the request inputs, the cross-domain req/ack pair and the status outputs.
// Ports (signals): btn_n, sw_req, wdt_en, wdt_kick, ack_in (to initiator);
//   req_out, busy, done_pulse, timeout_err, req_count (from initiator).
// Modports: master = the initiator, slave = its environment.
interface rst_req_initiator_if;
  import rst_req_initiator_pkg::*;

  logic                   btn_n;
  logic                   sw_req;
  logic                   wdt_en;
  logic                   wdt_kick;
  logic                   ack_in;
  logic                   req_out;
  logic                   busy;
  logic                   done_pulse;
  logic                   timeout_err;
  logic [REQ_COUNT_W-1:0] req_count;

  modport master (
    input  btn_n, sw_req, wdt_en, wdt_kick, ack_in,
    output req_out, busy, done_pulse, timeout_err, req_count
  );

  modport slave (
    output btn_n, sw_req, wdt_en, wdt_kick, ack_in,
    input  req_out, busy, done_pulse, timeout_err, req_count
  );

endinterface

// File: rtl/rst_req_initiator_btn_debounce.sv
// rtl/rst_req_initiator_btn_debounce.sv - push-button level debouncer
// Purpose: accepts a new button level only after DEBOUNCE_CYCLES consecutive cycles of
//   disagreement with the current level; reports a one-cycle pulse on each accepted fall.
// Ports: clk_in, rst_in (async, active-low), din (synchronised level),
//   dout (debounced level, resets to 1), fall_pulse (one cycle when dout goes 1->0).
module btn_debounce
  import rst_req_initiator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic din,
  output logic dout,
  output logic fall_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt        <= '0;
      dout       <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= 1'b0;
      if (din == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // This is the DEBOUNCE_CYCLES-th disagreeing cycle: accept the new level.
        cnt        <= '0;
        dout       <= din;
        fall_pulse <= ~din;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rst_req_initiator.sv
// rtl/rst_req_initiator.sv - initiator side of the 4-phase reset req/ack handshake
// Purpose: merges button, software and watchdog reset requests into one pending flag and
//   runs req/ack toward the clk_sys reset stretcher with per-edge ack timeouts.
// Ports: clk_in, rst_in (async, active-low), bus (rst_req_initiator_if.master):
//   btn_n, sw_req, wdt_en, wdt_kick, ack_in in; req_out, busy, done_pulse,
//   timeout_err, req_count out (all registered).
module rst_req_initiator
  import rst_req_initiator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int WDT_CYCLES      = 200_000_000,
  parameter int ACK_TIMEOUT     = 1024,
  parameter int SYNC_STAGES     = 2
) (
  input logic                  clk_in,
  input logic                  rst_in,
  rst_req_initiator_if.master  bus
);

  localparam int WW = cnt_width(WDT_CYCLES);
  localparam int TW = cnt_width(ACK_TIMEOUT);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] ack_sync;
  logic [1:0]             btn_sync;
  logic                   ack_s;
  logic                   btn_level;
  logic                   btn_fall;
  logic                   press;
  logic [WW-1:0]          wdt_cnt;
  logic                   wdt_evt;
  logic                   pending;
  logic                   src;
  logic                   leave_idle;
  state_t                 state, state_next;
  logic [TW-1:0]          tmr;
  logic                   req_q, req_next;
  logic                   busy_q, done_q, terr_q;
  logic [REQ_COUNT_W-1:0] count_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ack_sync <= '0;
      btn_sync <= 2'b11;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_in};
      btn_sync <= {btn_sync[0], bus.btn_n};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .din        (btn_sync[1]),
    .dout       (btn_level),
    .fall_pulse (btn_fall)
  );

  // The fall pulse is only ever raised together with a low level; qualifying keeps a
  // press from being seen while the debounced button reads released.
  assign press = btn_fall & ~btn_level;

  // Kick (or disable) wins over an expiry landing in the same cycle.
  assign wdt_evt = bus.wdt_en && !bus.wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wdt_cnt <= '0;
    end else if (!bus.wdt_en || bus.wdt_kick || wdt_evt) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WW'(1);
    end
  end

  assign src        = press | bus.sw_req | wdt_evt;
  assign leave_idle = (state == ST_IDLE) && (state_next != ST_IDLE);

  always_comb begin
    state_next = state;
    req_next   = req_q;
    unique case (state)
      ST_IDLE: begin
        // A stale ack still high from a previous exchange holds off the next request.
        if (pending && !ack_s) begin
          state_next = ST_REQ;
          req_next   = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_next = ST_REL;
          req_next   = 1'b0;
        end else if (tmr == TMO_LAST) begin
          state_next = ST_ERR;
          req_next   = 1'b0;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
          state_next = ST_DONE;
        end else if (tmr == TMO_LAST) begin
          state_next = ST_ERR;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR: begin
        if (!ack_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      pending <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_next;
      req_q   <= req_next;
      busy_q  <= (state_next != ST_IDLE);
      done_q  <= (state_next == ST_DONE);
      // A source arriving in the very cycle the FSM departs stays pending for later.
      pending <= (pending && !leave_idle) || src;
      if (state_next != state) begin
        tmr <= '0;
      end else if (tmr != TMO_LAST) begin
        tmr <= tmr + TW'(1);
      end
      if (state_next == ST_DONE) begin
        count_q <= count_q + REQ_COUNT_W'(1);
        terr_q  <= 1'b0;
      end else if (state_next == ST_ERR) begin
        terr_q  <= 1'b1;
      end
    end
  end

  assign bus.req_out     = req_q;
  assign bus.busy        = busy_q;
  assign bus.done_pulse  = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.req_count   = count_q;

endmodule
